// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared types and helpers for the branch target buffer.
//            - btb_entry_t : one table entry (valid, tag, target, jmp, ctr)
//            - SNT/WNT/WT/ST : 2-bit direction counter encodings
//            - bp_idx_w()  : index width helper
// Config   : BTB_BHT_EN adds the 2-bit direction counter to each entry.
// Revision : 1.0  initial release
// ============================================================================
package bp_pkg;

  // Entries are sized for the RV32 pipeline. Narrower tags are stored
  // zero-extended, so the field covers the smallest legal table (2 entries).
  localparam int BP_XLEN_MAX  = 32;
  localparam int BP_TAG_MAX_W = BP_XLEN_MAX - 3;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [BP_XLEN_MAX-1:0]  target;
    logic                    jmp;
`ifdef BTB_BHT_EN
    logic [1:0]              ctr;
`endif
  } btb_entry_t;

  function automatic int bp_idx_w(input int entries);
    return $clog2(entries);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_btb_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_btb_if
// Purpose  : Bundle between the pipeline (master) and the BTB (slave).
//   Lookup  : if_pc -> pred_hit, pred_taken, pred_next
//   Resolve : upd_valid, upd_pc, upd_is_br, upd_is_jmp, upd_taken,
//             upd_target, upd_pred_next, stall -> mispredict, redirect_pc
//   Perf    : perf_ctl, perf_mis
// Revision : 1.0  initial release
// ============================================================================
interface branch_predictor_btb_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_next;

  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_is_br;
  logic            upd_is_jmp;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic [XLEN-1:0] upd_pred_next;
  logic            stall;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  logic [31:0]     perf_ctl;
  logic [31:0]     perf_mis;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_is_br, upd_is_jmp, upd_taken,
           upd_target, upd_pred_next, stall,
    input  pred_hit, pred_taken, pred_next, mispredict, redirect_pc,
           perf_ctl, perf_mis
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_is_br, upd_is_jmp, upd_taken,
           upd_target, upd_pred_next, stall,
    output pred_hit, pred_taken, pred_next, mispredict, redirect_pc,
           perf_ctl, perf_mis
  );
endinterface
`default_nettype wire

// File: rtl/bp_sat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : bp_sat_ctr
// Purpose  : 2-bit saturating counter next-state function (combinational).
// Ports    : ctr      in  2  current counter
//            taken    in  1  resolved direction
//            ctr_next out 2  counter after the outcome, clamped to SNT..ST
// Revision : 1.0  initial release
// ============================================================================
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_btb
// Purpose  : Direct-mapped branch target buffer. IF looks it up
//            combinationally; ID reports resolved branches/jumps, which
//            update the table and raise mispredict with a redirect PC.
// Ports    : clk, reset (asynchronous, active-high)
//            bus (branch_predictor_btb_if.slave): lookup, resolution, perf
// Params   : XLEN (<= 32), ENTRIES (power of two, 2..256), CTR_INIT
// Config   : BTB_BHT_EN defined   -> per-entry 2-bit bimodal direction counter
//            BTB_BHT_EN undefined -> every hit is predicted taken
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = WNT
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_predictor_btb_if.slave  bus
);

  localparam int IDX_W = bp_idx_w(ENTRIES);

  btb_entry_t r_table [ENTRIES];

  // --------------------------------------------------------------------------
  // Lookup
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]        w_lk_idx;
  logic [BP_TAG_MAX_W-1:0] w_lk_tag;
  logic                    w_lk_hit;
  logic                    w_lk_taken;

  assign w_lk_idx = bus.if_pc[IDX_W+1:2];
  assign w_lk_tag = BP_TAG_MAX_W'(bus.if_pc[XLEN-1:IDX_W+2]);
  assign w_lk_hit = r_table[w_lk_idx].valid && (r_table[w_lk_idx].tag == w_lk_tag);

`ifdef BTB_BHT_EN
  assign w_lk_taken = w_lk_hit && (r_table[w_lk_idx].jmp || r_table[w_lk_idx].ctr[1]);
`else
  assign w_lk_taken = w_lk_hit;
`endif

  assign bus.pred_hit   = w_lk_hit;
  assign bus.pred_taken = w_lk_taken;
  assign bus.pred_next  = w_lk_taken ? r_table[w_lk_idx].target[XLEN-1:0]
                                     : bus.if_pc + XLEN'(4);

  // --------------------------------------------------------------------------
  // Resolution
  // --------------------------------------------------------------------------
  logic            w_upd_en;
  logic            w_act_taken;
  logic [XLEN-1:0] w_act_next;

  assign w_upd_en    = bus.upd_valid && !bus.stall;
  // A jump always transfers; bus.upd_taken only matters for branches.
  assign w_act_taken = bus.upd_is_jmp || (bus.upd_is_br && bus.upd_taken);
  assign w_act_next  = w_act_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);

  assign bus.mispredict  = w_upd_en && (w_act_next != bus.upd_pred_next);
  assign bus.redirect_pc = w_act_next;

  // --------------------------------------------------------------------------
  // Table write selection
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]        w_upd_idx;
  logic [BP_TAG_MAX_W-1:0] w_upd_tag;
  btb_entry_t              w_upd_ent;
  logic                    w_upd_hit;
  logic                    w_wr_en;
  btb_entry_t              w_wr_ent;

  assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
  assign w_upd_tag = BP_TAG_MAX_W'(bus.upd_pc[XLEN-1:IDX_W+2]);
  assign w_upd_ent = r_table[w_upd_idx];
  assign w_upd_hit = w_upd_ent.valid && (w_upd_ent.tag == w_upd_tag);

`ifdef BTB_BHT_EN
  logic [1:0] w_ctr_next;

  bp_sat_ctr u_sat_ctr (
    .ctr      (w_upd_ent.ctr),
    .taken    (bus.upd_taken),
    .ctr_next (w_ctr_next)
  );
`else
  // The counter reset value has no storage to land in without the BHT.
  logic w_unused_ctr_init;
  assign w_unused_ctr_init = ^CTR_INIT;
`endif

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_ent = w_upd_ent;
    if (w_upd_en) begin
      if (bus.upd_is_jmp) begin
        // Jump wins over a (malformed) simultaneous branch flag.
        w_wr_en         = 1'b1;
        w_wr_ent.valid  = 1'b1;
        w_wr_ent.tag    = w_upd_tag;
        w_wr_ent.target = BP_XLEN_MAX'(bus.upd_target);
        w_wr_ent.jmp    = 1'b1;
      end else if (bus.upd_is_br) begin
`ifdef BTB_BHT_EN
        if (w_upd_hit) begin
          w_wr_en      = 1'b1;
          w_wr_ent.jmp = 1'b0;
          w_wr_ent.ctr = w_ctr_next;
          if (bus.upd_taken) w_wr_ent.target = BP_XLEN_MAX'(bus.upd_target);
        end else if (bus.upd_taken) begin
          w_wr_en         = 1'b1;
          w_wr_ent.valid  = 1'b1;
          w_wr_ent.tag    = w_upd_tag;
          w_wr_ent.target = BP_XLEN_MAX'(bus.upd_target);
          w_wr_ent.jmp    = 1'b0;
          w_wr_ent.ctr    = WT;
        end
`else
        if (bus.upd_taken) begin
          w_wr_en         = 1'b1;
          w_wr_ent.valid  = 1'b1;
          w_wr_ent.tag    = w_upd_tag;
          w_wr_ent.target = BP_XLEN_MAX'(bus.upd_target);
          w_wr_ent.jmp    = 1'b0;
        end else if (w_upd_hit) begin
          w_wr_en        = 1'b1;
          w_wr_ent.valid = 1'b0;
        end
`endif
      end else if (w_upd_hit) begin
        // A non-control instruction sits where a taken transfer was cached.
        w_wr_en        = 1'b1;
        w_wr_ent.valid = 1'b0;
      end
    end
  end

  // Asynchronous reset wins over a same-cycle update, discarding it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= '0;
`ifdef BTB_BHT_EN
        r_table[i].ctr <= CTR_INIT;
`endif
      end
    end else if (w_wr_en) begin
      r_table[w_upd_idx] <= w_wr_ent;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters (saturating)
  // --------------------------------------------------------------------------
  logic [31:0] r_perf_ctl;
  logic [31:0] r_perf_mis;
  logic        w_ctl_evt;

  assign w_ctl_evt = w_upd_en && (bus.upd_is_br || bus.upd_is_jmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_ctl <= '0;
      r_perf_mis <= '0;
    end else begin
      if (w_ctl_evt && (r_perf_ctl != 32'hFFFF_FFFF))
        r_perf_ctl <= r_perf_ctl + 32'd1;
      if (bus.mispredict && (r_perf_mis != 32'hFFFF_FFFF))
        r_perf_mis <= r_perf_mis + 32'd1;
    end
  end

  assign bus.perf_ctl = r_perf_ctl;
  assign bus.perf_mis = r_perf_mis;

  // Word-aligned fetch: the low PC bits never select anything.
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

endmodule
`default_nettype wire
